// File: rtl/ivl_uvm_ovl_pkg.sv
// ivl_uvm_ovl_pkg: shared fire-bit indices and the
// event record used by the OVL fire collector.
package ivl_uvm_ovl_pkg;

  localparam int OVL_FIRE_2STATE = 0;
  localparam int OVL_FIRE_XCHECK = 1;
  localparam int OVL_FIRE_COVER  = 2;

  localparam int OVL_N_CHK = 4;
  localparam int OVL_TS_W  = 16;
  localparam int OVL_ID_W  = $clog2(OVL_N_CHK);

  typedef struct packed {
    logic [OVL_ID_W-1:0] id;
    logic [2:0]          fire_type;
    logic [OVL_TS_W-1:0] ts;
  } ovl_fire_evt_t;

endpackage

// File: rtl/ivl_uvm_ovl_evt_fifo.sv
// ivl_uvm_ovl_evt_fifo: synchronous first-word
// fall-through FIFO with full/empty/level.
module ivl_uvm_ovl_evt_fifo
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        level <= level + LW'(1);
      else if (do_pop && !do_push)
        level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// ivl_uvm_ovl_fire_collector: captures OVL fire bits,
// arbitrates round-robin into an event FIFO, counts fails.
module ivl_uvm_ovl_fire_collector
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int N_CHK = 4,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  localparam int ID_W = (N_CHK > 1) ? $clog2(N_CHK) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_CHK*3-1:0]     fire,
  input  logic [2:0]             type_mask,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [ID_W-1:0]        evt_id,
  output logic [2:0]             evt_type,
  output logic [TS_W-1:0]        evt_ts,
  output logic [N_CHK*CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0]       merge_cnt,
  output logic                   any_fail,
  output logic [LW-1:0]          fifo_level
);

  localparam int DW = ID_W + 3 + TS_W;
  localparam int SW = CNT_W + ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  ts;
  logic [2:0]       pending [N_CHK];
  logic [TS_W-1:0]  ts_lat  [N_CHK];
  logic [CNT_W-1:0] fcnt    [N_CHK];
  logic [ID_W-1:0]  rr_ptr;

  logic [2:0]       m [N_CHK];
  logic [N_CHK-1:0] req;
  logic [N_CHK-1:0] fail_hit;
  logic [N_CHK-1:0] merge_hit;
  logic [N_CHK-1:0] took;
  logic             gnt_vld;
  logic             gnt_fire;
  logic [ID_W-1:0]  gnt_id;
  logic             pop;
  logic             slot_free;
  logic [ID_W:0]    n_merge;
  logic [SW-1:0]    merge_sum;
  logic [DW-1:0]    push_data;
  logic [DW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;

  // Masked fire bits; unknown bits count as no fire.
  always_comb begin
    for (int i = 0; i < N_CHK; i++) begin
      for (int b = 0; b < 3; b++)
        m[i][b] = enable && type_mask[b]
                  && (fire[3*i+b] === 1'b1);
      fail_hit[i] = m[i][OVL_FIRE_2STATE];
      req[i]      = (pending[i] != 3'b0);
    end
  end

  // Round-robin pick: first pending at or after rr_ptr.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = N_CHK - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_CHK);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign pop       = !fifo_empty && evt_ready;
  assign slot_free = !fifo_full || pop;
  assign gnt_fire  = gnt_vld && slot_free;
  assign push_data = {gnt_id, pending[gnt_id],
                      ts_lat[gnt_id]};

  // Per-checker grant/merge strobes and merge total.
  always_comb begin
    n_merge = '0;
    for (int i = 0; i < N_CHK; i++) begin
      took[i]      = gnt_fire && (gnt_id == ID_W'(i));
      merge_hit[i] = (m[i] != 3'b0) && req[i] && !took[i];
      if (merge_hit[i])
        n_merge = n_merge + (ID_W+1)'(1);
    end
    merge_sum = SW'(merge_cnt) + SW'(n_merge);
  end

  // Free-running timestamp and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts     <= '0;
      rr_ptr <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (gnt_fire)
        rr_ptr <= (gnt_id == ID_W'(N_CHK - 1)) ? '0
                  : gnt_id + ID_W'(1);
    end
  end

  // Pending capture: fresh on idle/granted, else merge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_CHK; i++) begin
        pending[i] <= '0;
        ts_lat[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHK; i++) begin
        if (m[i] != 3'b0 && (!req[i] || took[i])) begin
          pending[i] <= m[i];
          ts_lat[i]  <= ts;
        end else if (m[i] != 3'b0) begin
          pending[i] <= pending[i] | m[i];
        end else if (took[i]) begin
          pending[i] <= '0;
        end
      end
    end
  end

  // Saturating fail/merge counters and sticky fail flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_CHK; i++)
        fcnt[i] <= '0;
      merge_cnt <= '0;
      any_fail  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CHK; i++)
        if (fail_hit[i] && fcnt[i] != CNT_MAX)
          fcnt[i] <= fcnt[i] + CNT_W'(1);
      if (merge_sum > SW'(CNT_MAX))
        merge_cnt <= CNT_MAX;
      else
        merge_cnt <= merge_sum[CNT_W-1:0];
      if (fail_hit != '0)
        any_fail <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CHK; g++) begin : g_cnt
    assign fail_cnt[CNT_W*g +: CNT_W] = fcnt[g];
  end

  ivl_uvm_ovl_evt_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (gnt_fire),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign evt_valid = !fifo_empty;
  assign {evt_id, evt_type, evt_ts} =
    fifo_empty ? DW'(0) : head;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// tb_ivl_uvm_ovl_fire_collector: vector table, corner
// sequences and random traffic against a queue model.
module tb_ivl_uvm_ovl_fire_collector;
  import ivl_uvm_ovl_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int TW = 16;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [11:0]   fire = '0;
  logic [2:0]    type_mask = 3'b111;
  logic          evt_ready = 1'b1;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic [2:0]    evt_type;
  logic [TW-1:0] evt_ts;
  logic [15:0]   fail_cnt;
  logic [CW-1:0] merge_cnt;
  logic          any_fail;
  logic [2:0]    fifo_level;

  ivl_uvm_ovl_fire_collector #(
    .N_CHK (N),
    .DEPTH (D),
    .TS_W  (TW),
    .CNT_W (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fire       (fire),
    .type_mask  (type_mask),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .evt_type   (evt_type),
    .evt_ts     (evt_ts),
    .fail_cnt   (fail_cnt),
    .merge_cnt  (merge_cnt),
    .any_fail   (any_fail),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
  endfunction

  // Reference model: pending records, counters, event queue.
  logic [TW-1:0]  m_ts;
  logic [2:0]     m_pend [N];
  logic [TW-1:0]  m_tsl  [N];
  int             m_rr;
  int             m_fail [N];
  int             m_merge;
  bit             m_any;
  ovl_fire_evt_t  q[$];

  function automatic void model_step();
    bit            pop;
    bit            slot;
    int            g;
    int            idx;
    logic [2:0]    mm;
    ovl_fire_evt_t e;
    if (reset) begin
      m_ts = '0;
      m_rr = 0;
      m_merge = 0;
      m_any = 1'b0;
      q.delete();
      for (int i = 0; i < N; i++) begin
        m_pend[i] = '0;
        m_tsl[i]  = '0;
        m_fail[i] = 0;
      end
      return;
    end
    pop  = (q.size() > 0) && evt_ready;
    slot = (q.size() < D) || pop;
    g = -1;
    e = '0;
    if (slot)
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && m_pend[idx] != 0)
          g = idx;
      end
    if (g >= 0) begin
      e.id = 2'(g);
      e.fire_type = m_pend[g];
      e.ts = m_tsl[g];
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      mm = enable ? (fire[3*i +: 3] & type_mask) : 3'b0;
      if (mm != 0) begin
        if (m_pend[i] == 0 || i == g) begin
          m_pend[i] = mm;
          m_tsl[i]  = m_ts;
        end else begin
          m_pend[i] = m_pend[i] | mm;
          m_merge++;
        end
      end else if (i == g) begin
        m_pend[i] = '0;
      end
      if (mm[0]) begin
        m_any = 1'b1;
        if (m_fail[i] < 15)
          m_fail[i]++;
      end
    end
    if (m_merge > 15)
      m_merge = 15;
    if (pop)
      void'(q.pop_front());
    if (g >= 0)
      q.push_back(e);
    m_ts = m_ts + TW'(1);
  endfunction

  function automatic void check_model();
    ovl_fire_evt_t h;
    logic [15:0]   ef;
    h = '0;
    if (q.size() > 0)
      h = q[0];
    for (int i = 0; i < N; i++)
      ef[4*i +: 4] = 4'(m_fail[i]);
    chk("m_valid", evt_valid, q.size() > 0);
    chk("m_id", evt_id, h.id);
    chk("m_type", evt_type, h.fire_type);
    chk("m_ts", evt_ts, h.ts);
    chk("m_level", fifo_level, q.size());
    chk("m_fail", fail_cnt, ef);
    chk("m_merge", merge_cnt, m_merge);
    chk("m_any", any_fail, m_any);
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model();
  endtask

  task automatic idle_to(int t);
    int guard;
    guard = 0;
    fire = '0;
    while (m_ts != TW'(t) && guard < 70000) begin
      tick();
      guard++;
    end
    if (guard >= 70000) begin
      n_total++;
      $display("FAIL idle_to timeout: ts %0d wanted %0d",
               m_ts, t);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [11:0] fire;
    int          n;
    bit          v;
    int          id;
    int          typ;
    int          ts;
    int          lvl;
    logic [15:0] fail;
    int          merge;
    bit          any;
  } vec_t;

  vec_t tv[16];

  initial begin
    int cnt;
    int ids[5];
    int tys[5];
    int tss[5];
    int eid[5] = '{0, 1, 2, 3, 1};
    int ety[5] = '{1, 1, 1, 1, 3};
    int ets[5] = '{30, 30, 30, 30, 40};

    tv[0]  = '{1, 12'hFFF, 1,  0, 0, 0, 0,  0, 16'h0000, 0, 0};
    tv[1]  = '{1, 12'h249, 1,  0, 0, 0, 0,  0, 16'h0000, 0, 0};
    tv[2]  = '{1, 12'hFFF, 1,  0, 0, 0, 0,  0, 16'h0000, 0, 0};
    tv[3]  = '{0, 12'h000, 10, 0, 0, 0, 0,  0, 16'h0000, 0, 0};
    tv[4]  = '{0, 12'h040, 1,  0, 0, 0, 0,  0, 16'h0100, 0, 1};
    tv[5]  = '{0, 12'h000, 1,  1, 2, 1, 10, 1, 16'h0100, 0, 1};
    tv[6]  = '{0, 12'h000, 1,  0, 0, 0, 0,  0, 16'h0100, 0, 1};
    tv[7]  = '{1, 12'h000, 1,  0, 0, 0, 0,  0, 16'h0000, 0, 0};
    tv[8]  = '{0, 12'h000, 20, 0, 0, 0, 0,  0, 16'h0000, 0, 0};
    tv[9]  = '{0, 12'h209, 1,  0, 0, 0, 0,  0, 16'h1011, 0, 1};
    tv[10] = '{0, 12'h000, 1,  1, 0, 1, 20, 1, 16'h1011, 0, 1};
    tv[11] = '{0, 12'h000, 1,  1, 1, 1, 20, 1, 16'h1011, 0, 1};
    tv[12] = '{0, 12'h000, 1,  1, 3, 1, 20, 1, 16'h1011, 0, 1};
    tv[13] = '{0, 12'h001, 1,  0, 0, 0, 0,  0, 16'h1012, 0, 1};
    tv[14] = '{0, 12'h000, 1,  1, 0, 1, 24, 1, 16'h1012, 0, 1};
    tv[15] = '{0, 12'h000, 1,  0, 0, 0, 0,  0, 16'h1012, 0, 1};

    // Reset, single fire, simultaneous fires, rr wrap.
    for (int r = 0; r < 16; r++) begin
      reset = tv[r].rst;
      fire  = tv[r].fire;
      repeat (tv[r].n) tick();
      chk($sformatf("vec%0d valid", r), evt_valid, tv[r].v);
      chk($sformatf("vec%0d id", r), evt_id, tv[r].id);
      chk($sformatf("vec%0d type", r), evt_type, tv[r].typ);
      chk($sformatf("vec%0d ts", r), evt_ts, tv[r].ts);
      chk($sformatf("vec%0d level", r), fifo_level, tv[r].lvl);
      chk($sformatf("vec%0d fail", r), fail_cnt, tv[r].fail);
      chk($sformatf("vec%0d merge", r), merge_cnt, tv[r].merge);
      chk($sformatf("vec%0d any", r), any_fail, tv[r].any);
    end

    // Backpressure: fill, merge into pending, then drain.
    reset = 1'b1;
    fire = '0;
    tick();
    reset = 1'b0;
    evt_ready = 1'b0;
    idle_to(30);
    fire = 12'h249;
    tick();
    fire = '0;
    repeat (4) tick();
    chk("bp full level", fifo_level, 4);
    idle_to(40);
    fire = 12'h008;
    tick();
    fire = '0;
    tick();
    fire = 12'h010;
    tick();
    fire = '0;
    chk("bp merge", merge_cnt, 1);
    chk("bp level", fifo_level, 4);
    chk("bp fail", fail_cnt, 16'h1121);
    evt_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12 && cnt < 5; c++) begin
      if (evt_valid) begin
        ids[cnt] = evt_id;
        tys[cnt] = evt_type;
        tss[cnt] = evt_ts;
        cnt++;
      end
      tick();
    end
    chk("bp drain count", cnt, 5);
    for (int k = 0; k < cnt; k++) begin
      chk($sformatf("bp ev%0d id", k), ids[k], eid[k]);
      chk($sformatf("bp ev%0d type", k), tys[k], ety[k]);
      chk($sformatf("bp ev%0d ts", k), tss[k], ets[k]);
    end
    repeat (2) tick();

    // Saturation of fail and merge counters.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    evt_ready = 1'b0;
    fire = 12'h200;
    repeat (20) tick();
    chk("sat fail", fail_cnt, 16'hF000);
    chk("sat merge", merge_cnt, 15);
    chk("sat level", fifo_level, 4);
    repeat (4) tick();
    chk("sat fail hold", fail_cnt, 16'hF000);
    chk("sat merge hold", merge_cnt, 15);
    fire = '0;

    // Reset mid-operation with three events queued.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fire = 12'h049;
    tick();
    fire = '0;
    repeat (3) tick();
    chk("mid level3", fifo_level, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid valid", evt_valid, 0);
    chk("mid level", fifo_level, 0);
    chk("mid fail", fail_cnt, 0);
    chk("mid merge", merge_cnt, 0);
    chk("mid any", any_fail, 0);
    evt_ready = 1'b1;
    fire = 12'h001;
    tick();
    fire = '0;
    tick();
    chk("mid restart valid", evt_valid, 1);
    chk("mid restart ts", evt_ts, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      evt_ready = (c % 400 < 200)
                  ? ($urandom_range(0, 3) != 0)
                  : ($urandom_range(0, 3) == 0);
      type_mask = ($urandom_range(0, 1) == 0)
                  ? 3'b111 : 3'($urandom_range(0, 7));
      for (int b = 0; b < 12; b++)
        fire[b] = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ivl_uvm_ovl_fire_collector.md
Name: ivl_uvm_ovl_fire_collector

Overview:
- Sits directly downstream of a bank of OVL checkers (ovl_change and siblings) and consumes their `fire` outputs.
- Counts failures per checker, timestamps each firing, and arbitrates simultaneous firings round-robin.
- Buffers fire events in an event FIFO drained by a UVM monitor through a valid/ready handshake.
- Replaces ad-hoc `$display` checking in OVL tests with a bench-observable event stream.

Parameters:
- N_CHK, 4: number of checkers; fire bus width is N_CHK*3.
- DEPTH, 8: event FIFO depth; power of two, at least 2.
- TS_W, 16: timestamp width.
- CNT_W, 8: width of the per-checker fail counter and of the merge counter.
- ID_W, derived: $clog2(N_CHK), minimum 1; localparam, not overridable.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  low: fire inputs ignored; timestamp still runs; drain still works.
- fire  in  N_CHK*3  checker i uses bits [3i+2:3i]: bit0 assertion fail, bit1 X-check, bit2 coverage.
- type_mask  in  3  per-type capture enable, applied to all checkers.
- evt_ready  in  1  consumer ready.
- evt_valid  out  1  FIFO head valid.
- evt_id  out  ID_W  checker index of the head event.
- evt_type  out  3  accumulated fire bits of the head event.
- evt_ts  out  TS_W  timestamp of the first fire of the head event.
- fail_cnt  out  N_CHK*CNT_W  per-checker saturating count of assertion fails (fire bit0); checker i at [CNT_W*i +: CNT_W].
- merge_cnt  out  CNT_W  saturating count of fires merged into an already-pending entry.
- any_fail  out  1  sticky; set by any counted bit0 fire.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: the following all go to 0 at the first clock edge with reset high:
  - ts, pending, rr_ptr, FIFO pointers and level;
  - evt_valid, evt_id, evt_type, evt_ts;
  - fail_cnt, merge_cnt, any_fail.
- Reset mid-operation discards FIFO contents and all pending entries; nothing is flushed to the consumer.
- Timestamp ts: 0 out of reset, +1 every cycle, wraps modulo 2^TS_W.
- Capture, per checker i, at each edge with enable=1:
  - m = fire[i] & type_mask.
  - If m != 0 and pending[i] == 0 (or is being granted this edge): pending[i] <= m; ts_lat[i] <= ts.
  - If m != 0 and pending[i] != 0 and checker i is not granted this edge: pending[i] <= pending[i] | m; ts_lat[i] is kept; merge_cnt += 1.
- Fail count: fail_cnt[i] += 1 whenever fire[i] bit0 & type_mask[0] & enable; saturates at 2^CNT_W-1, never wraps.
- Arbitration:
  - Requires any pending and a free FIFO slot.
  - A slot is free when level < DEPTH, or level == DEPTH with a pop this edge.
  - Grant the first pending index at or after rr_ptr, searching cyclically.
  - Push {id, pending, ts_lat}, clear that pending entry, set rr_ptr <= grant+1 mod N_CHK.
  - At most one push per cycle.
- Latency: an isolated fire sampled at edge E0 is pushed at E1; evt_valid is high after E1 (2 edges, empty FIFO).
- Handshake:
  - Pop when evt_valid & evt_ready.
  - evt_* stay stable while evt_valid & !evt_ready.
  - Push and pop in the same cycle leave the level unchanged.
  - Pop from an empty FIFO: no-op.
- FIFO full: no grant; pending entries hold; further fires merge (counted in merge_cnt). Events are never dropped, only merged.
- X on fire: treated as 0 for state update. The bench flags it, not the RTL.

Decomposition:
- Package ivl_uvm_ovl_pkg holds:
  - constants OVL_FIRE_2STATE=0, OVL_FIRE_XCHECK=1, OVL_FIRE_COVER=2;
  - typedef struct packed ovl_fire_evt_t {id, type, ts}, parameterised via package localparams matching the defaults.
- One sub-module: ivl_uvm_ovl_evt_fifo, a synchronous FIFO with first-word fall-through, full/empty and level outputs.
- Capture, arbiter, counters and timestamp stay in the top module.

Test Plan:
- All scenarios use N_CHK=4, DEPTH=4, TS_W=16, CNT_W=4, type_mask=3'b111.
- Reset check: hold reset 3 cycles with fire toggling -> evt_valid=0, fail_cnt=0, merge_cnt=0, any_fail=0, fifo_level=0.
- Single fire: checker 2 fire=3'b001 for one cycle at ts=10, ready=1 -> evt_valid two edges later with id=2, type=001, ts=10; fail_cnt[2]=1; any_fail=1.
- Simultaneous fire: checkers 0, 1 and 3 fire 3'b001 at ts=20 -> three events on consecutive cycles, ids 0, 1, 3, all ts=20; then checker 0 fires again -> rr_ptr resumes after 3 and grants 0.
- Backpressure: ready=0, fill the FIFO with 4 events, then checker 1 fires 001 at ts=40 and 010 at ts=42 -> merge_cnt=1, fifo_level=4; raise ready -> 4 events drain, then id=1, type=011, ts=40.
- Saturation: checker 3 fires bit0 for 20 consecutive cycles -> fail_cnt[3]=15; merge_cnt increments on fires landing while entry 3 is pending and not granted.
- Reset mid-operation: fifo_level=3, assert reset 1 cycle -> next cycle evt_valid=0, fifo_level=0, ts restarts at 0, counters 0.
